bl_order_seq: RTL and testbench

BL_ORDER_SEQ -- requirements
Module: bl_order_seq

---
 rtl/bl_order_seq.sv | 107 ++++++++++
 tb/tb_bl_order_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bl_order_seq.sv
// Baseline ordering sequencer: walks every antenna pair of a frame once (plus the
// half-span repeats) and tags each with its accumulation buffer and triangle side.
module bl_order_seq #(
  parameter int N_ANTS  = 16,
  parameter int N_BUFS  = 2,
  parameter int ACC_LEN = 1,
  localparam int AW = $clog2(N_ANTS),
  localparam int BW = $clog2(N_BUFS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync,
  input  logic          en,
  output logic [AW-1:0] ant_a,
  output logic [AW-1:0] ant_b,
  output logic [BW-1:0] buf_sel,
  output logic          last_triangle,
  output logic          dup,
  output logic          vld,
  output logic          frame_last,
  output logic          acc_last
);

  localparam int FW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [AW-1:0] HALF    = AW'(N_ANTS / 2);
  localparam logic [AW-1:0] LAST_B  = AW'(N_ANTS - 1);
  localparam logic [FW-1:0] FC_LAST = FW'(ACC_LEN - 1);

  logic [AW-1:0] r_b;
  logic [AW-1:0] r_k;
  logic [FW-1:0] r_frame_cnt;
  logic [BW-1:0] r_buf_idx;

  logic [AW-1:0] w_a;
  logic [BW-1:0] w_buf_sel;
  logic          w_step;
  logic          w_frame_end;
  logic          w_dup;

  // Derived pair and tags from the current (pre-update) state.
  always_comb begin
    w_a         = r_b + HALF + r_k;
    w_step      = en & ~sync;
    w_frame_end = (r_b == LAST_B) && (r_k == HALF);
    w_dup       = (r_k == {AW{1'b0}}) && (r_b >= HALF);
    // Pairs in the upper triangle belong to the accumulation that just closed.
    if (w_a > r_b) begin
      w_buf_sel = r_buf_idx - BW'(1);
    end else begin
      w_buf_sel = r_buf_idx;
    end
  end

  // Sequence, frame and buffer state; sync restarts regardless of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b         <= {AW{1'b0}};
      r_k         <= {AW{1'b0}};
      r_frame_cnt <= {FW{1'b0}};
      r_buf_idx   <= {BW{1'b0}};
    end else if (sync) begin
      r_b         <= {AW{1'b0}};
      r_k         <= {AW{1'b0}};
      r_frame_cnt <= {FW{1'b0}};
      r_buf_idx   <= {BW{1'b0}};
    end else if (en) begin
      if (r_k < HALF) begin
        r_k <= r_k + AW'(1);
      end else begin
        r_k <= {AW{1'b0}};
        r_b <= r_b + AW'(1);
      end
      if (w_frame_end) begin
        if (r_frame_cnt == FC_LAST) begin
          r_frame_cnt <= {FW{1'b0}};
          r_buf_idx   <= r_buf_idx + BW'(1);
        end else begin
          r_frame_cnt <= r_frame_cnt + FW'(1);
        end
      end
    end
  end

  // Registered outputs, one cycle behind the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ant_a         <= {AW{1'b0}};
      ant_b         <= {AW{1'b0}};
      buf_sel       <= {BW{1'b0}};
      last_triangle <= 1'b0;
      dup           <= 1'b0;
      vld           <= 1'b0;
      frame_last    <= 1'b0;
      acc_last      <= 1'b0;
    end else begin
      ant_a         <= w_a;
      ant_b         <= r_b;
      buf_sel       <= w_buf_sel;
      last_triangle <= (w_a > r_b);
      dup           <= w_dup;
      vld           <= w_step;
      frame_last    <= w_step & w_frame_end;
      acc_last      <= w_step & w_frame_end & (r_frame_cnt == FC_LAST);
    end
  end

endmodule

// File: tb/tb_bl_order_seq.sv
// Scoreboard bench for bl_order_seq: expected outputs come from a baseline-index
// model (frame position -> pair) and are checked by a separate negedge monitor.
module tb_bl_order_seq;

  localparam int NA = 16;
  localparam int NB = 4;
  localparam int AL = 2;
  localparam int FL = NA * (NA / 2 + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0;
  logic       en = 1'b0;
  logic [3:0] ant_a, ant_b;
  logic [1:0] buf_sel;
  logic       last_triangle, dup, vld, frame_last, acc_last;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] bs;
    logic       lt;
    logic       dp;
    logic       vl;
    logic       fl;
    logic       al;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   have_pend = 1'b0;
  int   n = 0;

  exp_t mon_act, mon_exp;
  int   fv = 0;
  int   fd = 0;
  bit   active = 1'b0;

  bl_order_seq #(.N_ANTS(NA), .N_BUFS(NB), .ACC_LEN(AL)) dut (
    .clk(clk), .rst(rst), .sync(sync), .en(en),
    .ant_a(ant_a), .ant_b(ant_b), .buf_sel(buf_sel),
    .last_triangle(last_triangle), .dup(dup), .vld(vld),
    .frame_last(frame_last), .acc_last(acc_last)
  );

  always #5 clk = ~clk;

  // Baseline number idx since restart -> frame f, position p; pair is (b, b+N/2+k).
  function automatic exp_t model(input int idx, input logic e, input logic s);
    exp_t x;
    int p, f, b, k, a, bi, fc;
    p  = idx % FL;
    f  = idx / FL;
    b  = p / (NA / 2 + 1);
    k  = p % (NA / 2 + 1);
    a  = (b + NA / 2 + k) % NA;
    bi = (f / AL) % NB;
    fc = f % AL;
    x.a  = 4'(a);
    x.b  = 4'(b);
    x.lt = (a > b);
    x.bs = (a <= b) ? 2'(bi) : 2'((bi + NB - 1) % NB);
    x.dp = (k == 0) && (b >= NA / 2);
    x.vl = e && !s;
    x.fl = x.vl && (p == FL - 1);
    x.al = x.fl && (fc == AL - 1);
    return x;
  endfunction

  task automatic step(input logic e, input logic s, input logic r);
    @(posedge clk);
    if (have_pend) q.push_back(pend);
    #1;
    rst  = r;
    en   = e;
    sync = s;
    if (rst) begin
      pend = '0;
      n    = 0;
    end else begin
      pend = model(n, e, s);
      if (s) n = 0;
      else if (e) n = n + 1;
    end
    have_pend = 1'b1;
  endtask

  // Reset pulse placed between a negedge and the following posedge.
  task automatic rst_pulse();
    step(1'b1, 1'b0, 1'b0);
    #5;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({ant_a, ant_b, buf_sel, last_triangle, dup, vld, frame_last, acc_last} != 17'd0) begin
      n_fail++;
      $display("FAIL rst_async: outputs=%h expected 0", {ant_a, ant_b, buf_sel, last_triangle, dup, vld, frame_last, acc_last});
    end
    #1;
    rst  = 1'b0;
    n    = 0;
    pend = model(n, en, sync);
    if (sync) n = 0;
    else if (en) n = n + 1;
  endtask

  // Monitor: pop one expectation per cycle, plus per-frame dup/length checks.
  always @(negedge clk) begin
    mon_act = {ant_a, ant_b, buf_sel, last_triangle, dup, vld, frame_last, acc_last};
    if (q.size() > 0) begin
      mon_exp = q.pop_front();
      n_tests++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got a=%0d b=%0d bs=%0d lt=%b dup=%b vld=%b fl=%b al=%b, want a=%0d b=%0d bs=%0d lt=%b dup=%b vld=%b fl=%b al=%b",
                 $time, mon_act.a, mon_act.b, mon_act.bs, mon_act.lt, mon_act.dp, mon_act.vl, mon_act.fl, mon_act.al,
                 mon_exp.a, mon_exp.b, mon_exp.bs, mon_exp.lt, mon_exp.dp, mon_exp.vl, mon_exp.fl, mon_exp.al);
      end
    end else if (vld === 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_vld t=%0t: vld=1 with no expectation", $time);
    end
    if (vld === 1'b1) begin
      if (ant_a == 4'd8 && ant_b == 4'd0 && !dup) begin
        fv = 0;
        fd = 0;
        active = 1'b1;
      end
      fv++;
      if (dup) begin
        fd++;
        if (active && fd == 1) begin
          n_tests++;
          if (fv != 73) begin
            n_fail++;
            $display("FAIL first_dup_pos: got vld #%0d want 73", fv);
          end
        end
      end
      if (frame_last && active) begin
        n_tests += 2;
        if (fv != FL) begin
          n_fail++;
          $display("FAIL frame_len: got %0d want %0d", fv, FL);
        end
        if (fd != NA / 2) begin
          n_fail++;
          $display("FAIL dup_count: got %0d want %0d", fd, NA / 2);
        end
        active = 1'b0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    // Eight full frames continuously: buffer index wraps back to 0.
    for (int i = 0; i < 8 * FL + 10; i++) step(1'b1, 1'b0, 1'b0);
    // Randomly gated enable.
    for (int i = 0; i < 400; i++) step(($urandom_range(0, 3) != 0), 1'b0, 1'b0);
    // Restart, then sync together with en on the 50th baseline of a frame.
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 49; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(($urandom_range(0, 1) != 0), 1'b0, 1'b0);
    // Asynchronous reset pulse mid-frame, then a full frame afterwards.
    rst_pulse();
    for (int i = 0; i < FL + 40; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) step(($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
